// File: rtl/sa_waddr_arbiter_if.sv
// AW request/grant bundle between the per-master dispatchers, the slave port and the W-data multiplexer.
// Signal names keep the dispatcher/slave naming so the arbiter's ports read the same as its neighbours.
interface sa_waddr_arbiter_if #(
    parameter int MST_AMT           = 2,
    parameter int ADDR_WIDTH        = 32,
    parameter int TRANS_MST_ID_W    = 5,
    parameter int TRANS_BURST_W     = 2,
    parameter int TRANS_DATA_LEN_W  = 3,
    parameter int TRANS_DATA_SIZE_W = 3,
    parameter int MST_ID_W          = $clog2(MST_AMT)
);
    logic [TRANS_MST_ID_W*MST_AMT-1:0]    m_AWID_i;
    logic [ADDR_WIDTH*MST_AMT-1:0]        m_AWADDR_i;
    logic [TRANS_BURST_W*MST_AMT-1:0]     m_AWBURST_i;
    logic [TRANS_DATA_LEN_W*MST_AMT-1:0]  m_AWLEN_i;
    logic [TRANS_DATA_SIZE_W*MST_AMT-1:0] m_AWSIZE_i;
    logic [MST_AMT-1:0]                   m_AWVALID_i;
    logic [MST_AMT-1:0]                   m_AWREADY_o;

    logic [MST_ID_W+TRANS_MST_ID_W-1:0]   s_AWID_o;
    logic [ADDR_WIDTH-1:0]                s_AWADDR_o;
    logic [TRANS_BURST_W-1:0]             s_AWBURST_o;
    logic [TRANS_DATA_LEN_W-1:0]          s_AWLEN_o;
    logic [TRANS_DATA_SIZE_W-1:0]         s_AWSIZE_o;
    logic                                 s_AWVALID_o;
    logic                                 s_AWREADY_i;

    logic [MST_ID_W-1:0]                  dsp_WDATA_mst_id_o;
    logic                                 dsp_WDATA_valid_o;
    logic                                 dsp_WDATA_pop_i;
    logic                                 order_full_o;

    // Arbiter side
    modport slave (
        input  m_AWID_i, m_AWADDR_i, m_AWBURST_i, m_AWLEN_i, m_AWSIZE_i, m_AWVALID_i,
        input  s_AWREADY_i, dsp_WDATA_pop_i,
        output m_AWREADY_o,
        output s_AWID_o, s_AWADDR_o, s_AWBURST_o, s_AWLEN_o, s_AWSIZE_o, s_AWVALID_o,
        output dsp_WDATA_mst_id_o, dsp_WDATA_valid_o, order_full_o
    );

    // Dispatcher / slave / W-mux side
    modport master (
        output m_AWID_i, m_AWADDR_i, m_AWBURST_i, m_AWLEN_i, m_AWSIZE_i, m_AWVALID_i,
        output s_AWREADY_i, dsp_WDATA_pop_i,
        input  m_AWREADY_o,
        input  s_AWID_o, s_AWADDR_o, s_AWBURST_o, s_AWLEN_o, s_AWSIZE_o, s_AWVALID_o,
        input  dsp_WDATA_mst_id_o, dsp_WDATA_valid_o, order_full_o
    );
endinterface

// File: rtl/sa_waddr_arbiter.sv
// Round-robin AW arbiter for one slave; winner goes to a one-entry output register, grant order to an order FIFO.
// Latency: master handshake in cycle N -> s_AWVALID_o and FIFO head valid in cycle N+1.
// Backpressure: no grant while the output register is held (s_AWREADY_i low) or the order FIFO is full.
module sa_waddr_arbiter #(
    parameter int MST_AMT           = 2,
    parameter int OUTSTANDING_AMT   = 8,
    parameter int ADDR_WIDTH        = 32,
    parameter int TRANS_MST_ID_W    = 5,
    parameter int TRANS_BURST_W     = 2,
    parameter int TRANS_DATA_LEN_W  = 3,
    parameter int TRANS_DATA_SIZE_W = 3,
    parameter int MST_ID_W          = $clog2(MST_AMT)
) (
    input  logic              ACLK_i,
    input  logic              ARESET_i,
    sa_waddr_arbiter_if.slave bus
);
    localparam int PTR_W = $clog2(OUTSTANDING_AMT);
    localparam int CNT_W = $clog2(OUTSTANDING_AMT + 1);

    logic [MST_ID_W-1:0]          rr_ptr;
    logic [MST_ID_W-1:0]          rr_idx;
    logic [MST_ID_W-1:0]          cand_idx;
    logic [MST_ID_W-1:0]          next_ptr;
    logic                         cand_found;
    logic                         accept;
    logic                         pop_eff;
    int                           rr_sum;

    logic [TRANS_MST_ID_W-1:0]    sel_id;
    logic [ADDR_WIDTH-1:0]        sel_addr;
    logic [TRANS_BURST_W-1:0]     sel_burst;
    logic [TRANS_DATA_LEN_W-1:0]  sel_len;
    logic [TRANS_DATA_SIZE_W-1:0] sel_size;

    logic [MST_ID_W-1:0]          order_mem [OUTSTANDING_AMT];
    logic [PTR_W-1:0]             wr_ptr;
    logic [PTR_W-1:0]             rd_ptr;
    logic [CNT_W-1:0]             order_cnt;

    // Scan masters starting at rr_ptr, wrapping at MST_AMT; first requester wins.
    always_comb begin
        cand_found = 1'b0;
        cand_idx   = '0;
        rr_sum     = 0;
        rr_idx     = '0;
        for (int k = 0; k < MST_AMT; k++) begin
            rr_sum = int'(rr_ptr) + k;
            if (rr_sum >= MST_AMT) begin
                rr_sum = rr_sum - MST_AMT;
            end
            rr_idx = MST_ID_W'(rr_sum);
            if (!cand_found && bus.m_AWVALID_i[rr_idx]) begin
                cand_found = 1'b1;
                cand_idx   = rr_idx;
            end
        end
    end

    always_comb begin
        sel_id    = '0;
        sel_addr  = '0;
        sel_burst = '0;
        sel_len   = '0;
        sel_size  = '0;
        for (int i = 0; i < MST_AMT; i++) begin
            if (cand_idx == MST_ID_W'(i)) begin
                sel_id    = bus.m_AWID_i[i*TRANS_MST_ID_W +: TRANS_MST_ID_W];
                sel_addr  = bus.m_AWADDR_i[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_burst = bus.m_AWBURST_i[i*TRANS_BURST_W +: TRANS_BURST_W];
                sel_len   = bus.m_AWLEN_i[i*TRANS_DATA_LEN_W +: TRANS_DATA_LEN_W];
                sel_size  = bus.m_AWSIZE_i[i*TRANS_DATA_SIZE_W +: TRANS_DATA_SIZE_W];
            end
        end
    end

    assign accept   = !ARESET_i && cand_found && (!bus.s_AWVALID_o || bus.s_AWREADY_i)
                      && !bus.order_full_o;
    assign next_ptr = (cand_idx == MST_ID_W'(MST_AMT - 1)) ? '0 : cand_idx + MST_ID_W'(1);

    always_comb begin
        bus.m_AWREADY_o = '0;
        for (int i = 0; i < MST_AMT; i++) begin
            bus.m_AWREADY_o[i] = accept && (cand_idx == MST_ID_W'(i));
        end
    end

    always_ff @(posedge ACLK_i) begin
        if (ARESET_i) begin
            rr_ptr          <= '0;
            bus.s_AWVALID_o <= 1'b0;
            bus.s_AWID_o    <= '0;
            bus.s_AWADDR_o  <= '0;
            bus.s_AWBURST_o <= '0;
            bus.s_AWLEN_o   <= '0;
            bus.s_AWSIZE_o  <= '0;
        end else if (accept) begin
            rr_ptr          <= next_ptr;
            bus.s_AWVALID_o <= 1'b1;
            bus.s_AWID_o    <= {cand_idx, sel_id};
            bus.s_AWADDR_o  <= sel_addr;
            bus.s_AWBURST_o <= sel_burst;
            bus.s_AWLEN_o   <= sel_len;
            bus.s_AWSIZE_o  <= sel_size;
        end else if (bus.s_AWREADY_i) begin
            bus.s_AWVALID_o <= 1'b0;
        end
    end

    // Order FIFO: push on master accept (already excludes full), pop only when non-empty.
    assign pop_eff                = bus.dsp_WDATA_pop_i && (order_cnt != '0);
    assign bus.order_full_o       = (order_cnt == CNT_W'(OUTSTANDING_AMT));
    assign bus.dsp_WDATA_valid_o  = (order_cnt != '0);
    assign bus.dsp_WDATA_mst_id_o = bus.dsp_WDATA_valid_o ? order_mem[rd_ptr] : '0;

    always_ff @(posedge ACLK_i) begin
        if (accept) begin
            order_mem[wr_ptr] <= cand_idx;
        end
    end

    always_ff @(posedge ACLK_i) begin
        if (ARESET_i) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            order_cnt <= '0;
        end else begin
            if (accept) begin
                wr_ptr <= (wr_ptr == PTR_W'(OUTSTANDING_AMT - 1)) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (pop_eff) begin
                rd_ptr <= (rd_ptr == PTR_W'(OUTSTANDING_AMT - 1)) ? '0 : rd_ptr + PTR_W'(1);
            end
            if (accept && !pop_eff) begin
                order_cnt <= order_cnt + CNT_W'(1);
            end else if (!accept && pop_eff) begin
                order_cnt <= order_cnt - CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_sa_waddr_arbiter.sv
// Bench for sa_waddr_arbiter: directed scenarios then random traffic, every cycle compared
// against a queue-based reference model of the round-robin grant, output register and order FIFO.
module tb_sa_waddr_arbiter;
    localparam int N   = 2;
    localparam int D   = 8;
    localparam int AW  = 32;
    localparam int IDW = 5;
    localparam int BW  = 2;
    localparam int LW  = 3;
    localparam int SW  = 3;
    localparam int MW  = 1;
    localparam int IDN = IDW * N;
    localparam int BWN = BW * N;
    localparam int LWN = LW * N;
    localparam int SWN = SW * N;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sa_waddr_arbiter_if #(
        .MST_AMT(N), .ADDR_WIDTH(AW), .TRANS_MST_ID_W(IDW), .TRANS_BURST_W(BW),
        .TRANS_DATA_LEN_W(LW), .TRANS_DATA_SIZE_W(SW), .MST_ID_W(MW)
    ) bus ();

    sa_waddr_arbiter #(
        .MST_AMT(N), .OUTSTANDING_AMT(D), .ADDR_WIDTH(AW), .TRANS_MST_ID_W(IDW),
        .TRANS_BURST_W(BW), .TRANS_DATA_LEN_W(LW), .TRANS_DATA_SIZE_W(SW), .MST_ID_W(MW)
    ) dut (
        .ACLK_i   (clk),
        .ARESET_i (rst),
        .bus      (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int              m_ptr;
    int              m_q[$];
    logic            m_vld;
    logic            m_clean;
    logic [MW+IDW-1:0] m_id;
    logic [AW-1:0]   m_addr;
    logic [BW-1:0]   m_burst;
    logic [LW-1:0]   m_len;
    logic [SW-1:0]   m_size;
    logic [AW-1:0]   hold_addr;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ptr   = 0;
        m_q.delete();
        m_vld   = 1'b0;
        m_clean = 1'b1;
        m_id    = '0;
        m_addr  = '0;
        m_burst = '0;
        m_len   = '0;
        m_size  = '0;
    endtask

    task automatic drive(input logic [N-1:0] v, input logic rdy, input logic pop);
        bus.m_AWVALID_i     = v;
        bus.s_AWREADY_i     = rdy;
        bus.dsp_WDATA_pop_i = pop;
    endtask

    task automatic rand_payload();
        bus.m_AWID_i    = IDN'($urandom());
        bus.m_AWADDR_i  = {$urandom(), $urandom()};
        bus.m_AWBURST_i = BWN'($urandom());
        bus.m_AWLEN_i   = LWN'($urandom());
        bus.m_AWSIZE_i  = SWN'($urandom());
    endtask

    task automatic check_outputs();
        chk("s_awvalid", 64'(bus.s_AWVALID_o), 64'(m_vld));
        if (m_vld || m_clean) begin
            chk("s_awid",    64'(bus.s_AWID_o),    64'(m_id));
            chk("s_awaddr",  64'(bus.s_AWADDR_o),  64'(m_addr));
            chk("s_awburst", 64'(bus.s_AWBURST_o), 64'(m_burst));
            chk("s_awlen",   64'(bus.s_AWLEN_o),   64'(m_len));
            chk("s_awsize",  64'(bus.s_AWSIZE_o),  64'(m_size));
        end
        chk("wdata_valid", 64'(bus.dsp_WDATA_valid_o), 64'(m_q.size() > 0));
        if (m_q.size() > 0) begin
            chk("wdata_mst_id", 64'(bus.dsp_WDATA_mst_id_o), 64'(m_q[0]));
        end else if (m_clean) begin
            chk("wdata_mst_id_rst", 64'(bus.dsp_WDATA_mst_id_o), 64'(0));
        end
        chk("order_full", 64'(bus.order_full_o), 64'(m_q.size() == D));
    endtask

    // Called at a falling edge with inputs already driven; returns at the next falling edge.
    task automatic cycle();
        int c;
        logic acc;
        logic [N-1:0] exp_rdy;
        #1;
        c = -1;
        for (int k = 0; k < N; k++) begin
            if (c < 0 && bus.m_AWVALID_i[(m_ptr + k) % N]) c = (m_ptr + k) % N;
        end
        acc = !rst && (c >= 0) && (!m_vld || bus.s_AWREADY_i) && (m_q.size() < D);
        exp_rdy = '0;
        if (acc) exp_rdy[c] = 1'b1;
        chk("m_awready", 64'(bus.m_AWREADY_o), 64'(exp_rdy));
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            if (bus.dsp_WDATA_pop_i && m_q.size() > 0) void'(m_q.pop_front());
            if (acc) begin
                m_q.push_back(c);
                m_vld   = 1'b1;
                m_clean = 1'b0;
                m_id    = {MW'(c), bus.m_AWID_i[c*IDW +: IDW]};
                m_addr  = bus.m_AWADDR_i[c*AW +: AW];
                m_burst = bus.m_AWBURST_i[c*BW +: BW];
                m_len   = bus.m_AWLEN_i[c*LW +: LW];
                m_size  = bus.m_AWSIZE_i[c*SW +: SW];
                m_ptr   = (c + 1) % N;
            end else if (bus.s_AWREADY_i) begin
                m_vld = 1'b0;
            end
        end
        @(negedge clk);
        check_outputs();
    endtask

    initial begin
        rst = 1'b1;
        drive('0, 1'b0, 1'b0);
        bus.m_AWID_i = '0; bus.m_AWADDR_i = '0; bus.m_AWBURST_i = '0;
        bus.m_AWLEN_i = '0; bus.m_AWSIZE_i = '0;
        model_reset();
        cycle();
        cycle();
        rst = 1'b0;

        // Single request from master 1
        bus.m_AWID_i[IDW +: IDW]  = 5'h03;
        bus.m_AWADDR_i[AW +: AW]  = 32'h4000_0010;
        drive(2'b10, 1'b1, 1'b0);
        #1 chk("single_rdy", 64'(bus.m_AWREADY_o), 64'h2);
        cycle();
        chk("single_id",   64'(bus.s_AWID_o), 64'h23);
        chk("single_addr", 64'(bus.s_AWADDR_o), 64'h4000_0010);
        chk("single_head", 64'(bus.dsp_WDATA_mst_id_o), 64'h1);
        drive('0, 1'b1, 1'b1);
        cycle();

        // Fairness: grants and pops alternate 0,1,0,1
        for (int k = 0; k < 4; k++) begin
            drive(2'b11, 1'b1, 1'b0);
            #1 chk("fair_grant", 64'(bus.m_AWREADY_o), (k % 2) ? 64'h2 : 64'h1);
            cycle();
        end
        for (int k = 0; k < 4; k++) begin
            drive('0, 1'b1, 1'b1);
            #1 chk("fair_pop", 64'(bus.dsp_WDATA_mst_id_o), 64'(k % 2));
            cycle();
        end

        // Backpressure: register held 5 cycles, then next master granted on the release cycle
        bus.m_AWADDR_i = {32'h4000_0010, 32'h1234_5678};
        hold_addr = 32'h1234_5678;
        drive(2'b11, 1'b1, 1'b0);
        cycle();
        for (int k = 0; k < 5; k++) begin
            drive(2'b11, 1'b0, 1'b0);
            #1 chk("bp_no_grant", 64'(bus.m_AWREADY_o), 64'h0);
            cycle();
            chk("bp_hold_addr", 64'(bus.s_AWADDR_o), 64'(hold_addr));
            chk("bp_hold_vld", 64'(bus.s_AWVALID_o), 64'h1);
        end
        drive(2'b11, 1'b1, 1'b0);
        #1 chk("bp_release_grant", 64'(bus.m_AWREADY_o), 64'h2);
        cycle();
        for (int k = 0; k < 3; k++) begin
            drive('0, 1'b1, 1'b1);
            cycle();
        end

        // Full: 8 accepts, 9th blocked until one pop
        for (int k = 0; k < D; k++) begin
            drive(2'b11, 1'b1, 1'b0);
            cycle();
        end
        chk("full_set", 64'(bus.order_full_o), 64'h1);
        drive(2'b11, 1'b1, 1'b0);
        #1 chk("full_blocks", 64'(bus.m_AWREADY_o), 64'h0);
        cycle();
        drive(2'b11, 1'b1, 1'b1);
        #1 chk("full_pop_no_push", 64'(bus.m_AWREADY_o), 64'h0);
        cycle();
        chk("full_clear", 64'(bus.order_full_o), 64'h0);
        drive(2'b11, 1'b1, 1'b0);
        #1 chk("full_ninth", 64'(bus.m_AWREADY_o), 64'h1);
        cycle();
        for (int k = 0; k < D + 1; k++) begin
            drive('0, 1'b1, 1'b1);
            cycle();
        end

        // Pop on empty, then push+pop at count 3
        drive('0, 1'b1, 1'b1);
        cycle();
        chk("empty_pop_valid", 64'(bus.dsp_WDATA_valid_o), 64'h0);
        for (int k = 0; k < 3; k++) begin
            drive(2'b11, 1'b1, 1'b0);
            cycle();
        end
        chk("pp_head_before", 64'(bus.dsp_WDATA_mst_id_o), 64'h1);
        drive(2'b11, 1'b1, 1'b1);
        cycle();
        chk("pp_head_after", 64'(bus.dsp_WDATA_mst_id_o), 64'h0);
        chk("pp_valid", 64'(bus.dsp_WDATA_valid_o), 64'h1);
        for (int k = 0; k < 3; k++) begin
            drive('0, 1'b1, 1'b1);
            cycle();
        end

        // Reset mid-operation
        for (int k = 0; k < 3; k++) begin
            drive(2'b11, 1'b1, 1'b0);
            rand_payload();
            cycle();
        end
        drive(2'b11, 1'b0, 1'b0);
        rst = 1'b1;
        #1 chk("rst_rdy_forced", 64'(bus.m_AWREADY_o), 64'h0);
        cycle();
        chk("rst_awvalid", 64'(bus.s_AWVALID_o), 64'h0);
        chk("rst_wvalid",  64'(bus.dsp_WDATA_valid_o), 64'h0);
        rst = 1'b0;
        drive(2'b11, 1'b1, 1'b0);
        #1 chk("rst_grant0", 64'(bus.m_AWREADY_o), 64'h1);
        cycle();

        // Random traffic
        for (int k = 0; k < 3000; k++) begin
            rand_payload();
            drive(N'($urandom()), $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
            rst = ($urandom_range(0, 299) == 0);
            cycle();
        end
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
